// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, response and shared-ALU signals of the two-port ALU arbiter
interface alu_arbiter_if;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req0_op, req1_shamt, req1_op;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shamt, alu_op;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_shamt, req0_op,
    input  req1_valid, req1_a, req1_b, req1_shamt, req1_op,
    input  rsp0_ready, rsp1_ready, alu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    output alu_a, alu_b, alu_shamt, alu_op
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_shamt, req0_op,
    output req1_valid, req1_a, req1_b, req1_shamt, req1_op,
    output rsp0_ready, rsp1_ready, alu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_result, rsp1_valid, rsp1_result,
    input  alu_a, alu_b, alu_shamt, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters with registered responses
module alu_arbiter #(
  parameter logic [4:0] IDLE_OP    = 5'd0,
  parameter int         FIRST_PORT = 0
) (
  input logic clk,
  input logic reset,
  alu_arbiter_if.slave bus
);
  logic last_grant, elig0, elig1, p0, p1, g0, g1;
  assign elig0 = bus.req0_valid && (!bus.rsp0_valid || bus.rsp0_ready);
  assign elig1 = bus.req1_valid && (!bus.rsp1_valid || bus.rsp1_ready);
  assign p0 = elig0 && (!elig1 || last_grant);
  assign p1 = elig1 && (!elig0 || !last_grant);
  // outputs see reset-gated grants; the flops are held by reset anyway
  assign g0 = p0 && !reset;
  assign g1 = p1 && !reset;
  assign bus.req0_ready = g0;
  assign bus.req1_ready = g1;
  assign bus.alu_a     = g0 ? bus.req0_a     : g1 ? bus.req1_a     : '0;
  assign bus.alu_b     = g0 ? bus.req0_b     : g1 ? bus.req1_b     : '0;
  assign bus.alu_shamt = g0 ? bus.req0_shamt : g1 ? bus.req1_shamt : '0;
  assign bus.alu_op    = g0 ? bus.req0_op    : g1 ? bus.req1_op    : IDLE_OP;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.rsp0_valid  <= 1'b0;
      bus.rsp1_valid  <= 1'b0;
      bus.rsp0_result <= '0;
      bus.rsp1_result <= '0;
      last_grant      <= (FIRST_PORT == 0);
    end else begin
      if (p0) begin
        bus.rsp0_result <= bus.alu_result;
        bus.rsp0_valid  <= 1'b1;
      end else if (bus.rsp0_ready) bus.rsp0_valid <= 1'b0;
      if (p1) begin
        bus.rsp1_result <= bus.alu_result;
        bus.rsp1_valid  <= 1'b1;
      end else if (bus.rsp1_ready) bus.rsp1_valid <= 1'b0;
      if (p0 || p1) last_grant <= p1;
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, handshakes, idle outputs and async reset
module tb_alu_arbiter;
  localparam logic [4:0] IDLE = 5'h0A, ADD = 5'd0, SUB = 5'd1, ORR = 5'd2, SLL = 5'd3;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  alu_arbiter_if bus();
  alu_arbiter #(.IDLE_OP(IDLE), .FIRST_PORT(0)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  always_comb
    bus.alu_result = bus.alu_op == ADD ? bus.alu_a + bus.alu_b :
                     bus.alu_op == SUB ? bus.alu_a - bus.alu_b :
                     bus.alu_op == ORR ? bus.alu_a | bus.alu_b :
                     bus.alu_op == SLL ? bus.alu_b << bus.alu_shamt : 32'd0;

  task clear_inputs;
    bus.req0_valid = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_shamt = 0; bus.req0_op = 0;
    bus.req1_valid = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_shamt = 0; bus.req1_op = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
  endtask

  task do_reset;
    @(negedge clk) reset = 1;
    @(negedge clk) reset = 0;
  endtask

  task test_reset;
    clear_inputs();
    bus.req0_valid = 1; bus.req1_valid = 1; bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    #1;
    total++; if (bus.req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b want=0", bus.req0_ready); end
    total++; if (bus.req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b want=0", bus.req1_ready); end
    total++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b%b want=00", bus.rsp0_valid, bus.rsp1_valid); end
    total++; if (bus.rsp0_result !== 0 || bus.rsp1_result !== 0) begin bad++; $display("FAIL reset_result got=%h/%h want=0", bus.rsp0_result, bus.rsp1_result); end
    total++; if (bus.alu_op !== IDLE || bus.alu_a !== 0) begin bad++; $display("FAIL reset_alu got op=%h a=%h want op=%h a=0", bus.alu_op, bus.alu_a, IDLE); end
    @(negedge clk);
    reset = 0;
    clear_inputs();
  endtask

  task test_single;
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 5; bus.req0_b = 3; bus.req0_op = ADD; bus.rsp0_ready = 1;
    #1;
    total++; if (bus.req0_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", bus.req0_ready); end
    total++; if (bus.alu_a !== 5 || bus.alu_b !== 3 || bus.alu_op !== ADD) begin bad++; $display("FAIL single_alu got a=%h b=%h op=%h want 5/3/%h", bus.alu_a, bus.alu_b, bus.alu_op, ADD); end
    @(posedge clk); #1;
    total++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 8) begin bad++; $display("FAIL single_rsp got v=%b r=%h want v=1 r=8", bus.rsp0_valid, bus.rsp0_result); end
    @(negedge clk) bus.req0_valid = 0;
    @(posedge clk); #1;
    total++; if (bus.rsp0_valid !== 1'b0 || bus.rsp0_result !== 8) begin bad++; $display("FAIL single_drain got v=%b r=%h want v=0 r=8", bus.rsp0_valid, bus.rsp0_result); end
    clear_inputs();
  endtask

  task test_contention;
    do_reset();
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 10; bus.req0_b = 4; bus.req0_op = SUB;
    bus.req1_valid = 1; bus.req1_a = 32'hF0; bus.req1_b = 32'h0F; bus.req1_op = ORR;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    for (int i = 0; i < 4; i++) begin
      logic e0;
      e0 = (i % 2 == 0);
      #1;
      total++; if (bus.req0_ready !== e0 || bus.req1_ready !== !e0) begin bad++; $display("FAIL cont_grant%0d got=%b%b want=%b%b", i, bus.req0_ready, bus.req1_ready, e0, !e0); end
      @(posedge clk); #1;
      total++; if (bus.rsp0_valid !== e0 || bus.rsp1_valid !== !e0) begin bad++; $display("FAIL cont_valid%0d got=%b%b want=%b%b", i, bus.rsp0_valid, bus.rsp1_valid, e0, !e0); end
      total++; if ((e0 ? bus.rsp0_result : bus.rsp1_result) !== (e0 ? 32'd6 : 32'hFF)) begin bad++; $display("FAIL cont_result%0d got=%h want=%h", i, e0 ? bus.rsp0_result : bus.rsp1_result, e0 ? 32'd6 : 32'hFF); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task test_backpressure;
    do_reset();
    @(negedge clk);
    bus.req1_valid = 1; bus.req1_a = 32'hF0; bus.req1_b = 32'h0F; bus.req1_op = ORR; bus.rsp1_ready = 0;
    #1;
    total++; if (bus.req1_ready !== 1'b1) begin bad++; $display("FAIL bp_first got=%b want=1", bus.req1_ready); end
    @(posedge clk); #1;
    total++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 32'hFF) begin bad++; $display("FAIL bp_held got v=%b r=%h want v=1 r=ff", bus.rsp1_valid, bus.rsp1_result); end
    @(negedge clk);
    bus.req1_b = 32'h100;
    bus.req0_valid = 1; bus.req0_a = 10; bus.req0_b = 4; bus.req0_op = SUB; bus.rsp0_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL bp_block%0d got=%b%b want=10", i, bus.req0_ready, bus.req1_ready); end
      @(posedge clk); #1;
      total++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 32'hFF || bus.rsp0_result !== 6) begin bad++; $display("FAIL bp_state%0d got v1=%b r1=%h r0=%h want 1/ff/6", i, bus.rsp1_valid, bus.rsp1_result, bus.rsp0_result); end
      @(negedge clk);
    end
    bus.rsp1_ready = 1;
    #1;
    total++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin bad++; $display("FAIL bp_release got=%b%b want=01", bus.req0_ready, bus.req1_ready); end
    @(posedge clk); #1;
    total++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 32'h1F0) begin bad++; $display("FAIL bp_new got v=%b r=%h want v=1 r=1f0", bus.rsp1_valid, bus.rsp1_result); end
    @(negedge clk);
    clear_inputs();
  endtask

  task test_back_to_back;
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_b = 1; bus.req0_op = SLL; bus.rsp0_ready = 1;
    for (int s = 1; s <= 3; s++) begin
      bus.req0_shamt = 5'(s);
      #1;
      total++; if (bus.req0_ready !== 1'b1 || bus.alu_shamt !== 5'(s)) begin bad++; $display("FAIL b2b_issue%0d got rdy=%b sh=%0d want 1/%0d", s, bus.req0_ready, bus.alu_shamt, s); end
      @(posedge clk); #1;
      total++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== (32'd1 << s)) begin bad++; $display("FAIL b2b_rsp%0d got v=%b r=%h want v=1 r=%h", s, bus.rsp0_valid, bus.rsp0_result, 32'd1 << s); end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task test_idle;
    #1;
    total++; if (bus.alu_a !== 0 || bus.alu_b !== 0 || bus.alu_shamt !== 0 || bus.alu_op !== IDLE) begin bad++; $display("FAIL idle_alu got a=%h b=%h sh=%h op=%h want 0/0/0/%h", bus.alu_a, bus.alu_b, bus.alu_shamt, bus.alu_op, IDLE); end
    total++; if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b%b want=00", bus.req0_ready, bus.req1_ready); end
    @(negedge clk);
    bus.req1_valid = 1; bus.req1_a = 7; bus.req1_b = 9; bus.req1_op = 5'h1F; bus.rsp1_ready = 1;
    #1;
    total++; if (bus.req1_ready !== 1'b1 || bus.alu_op !== 5'h1F || bus.alu_a !== 7) begin bad++; $display("FAIL unk_issue got rdy=%b op=%h a=%h want 1/1f/7", bus.req1_ready, bus.alu_op, bus.alu_a); end
    @(posedge clk); #1;
    total++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 0) begin bad++; $display("FAIL unk_rsp got v=%b r=%h want v=1 r=0", bus.rsp1_valid, bus.rsp1_result); end
    @(negedge clk);
    clear_inputs();
  endtask

  task test_async_reset;
    @(negedge clk);
    bus.req0_valid = 1; bus.req0_a = 5; bus.req0_b = 3; bus.req0_op = ADD; bus.rsp0_ready = 0;
    @(posedge clk); #1;
    total++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 8) begin bad++; $display("FAIL ar_before got v=%b r=%h want v=1 r=8", bus.rsp0_valid, bus.rsp0_result); end
    #2 reset = 1;
    #1;
    total++; if (bus.rsp0_valid !== 1'b0 || bus.rsp0_result !== 0) begin bad++; $display("FAIL ar_clear got v=%b r=%h want v=0 r=0", bus.rsp0_valid, bus.rsp0_result); end
    total++; if (bus.req0_ready !== 1'b0 || bus.alu_op !== IDLE) begin bad++; $display("FAIL ar_hold got rdy=%b op=%h want 0/%h", bus.req0_ready, bus.alu_op, IDLE); end
    @(negedge clk);
    reset = 0;
    bus.req1_valid = 1; bus.req1_a = 32'hF0; bus.req1_b = 32'h0F; bus.req1_op = ORR;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    #1;
    total++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin bad++; $display("FAIL ar_first got=%b%b want=10", bus.req0_ready, bus.req1_ready); end
    @(posedge clk); #1;
    total++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 8) begin bad++; $display("FAIL ar_reissue got v=%b r=%h want v=1 r=8", bus.rsp0_valid, bus.rsp0_result); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_back_to_back();
    test_idle();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter that shares the single combinational ALU between two requesters, such as the main pipeline's EX stage and a secondary issuer like a branch-compare or debug port. It accepts one operation per cycle, drives the shared ALU's operand and opcode inputs, and captures the result. Each requester gets its own one-entry response register with a valid/ready handshake. It sits directly in front of the ALU, and the ALU itself stays purely combinational.

## Interface
Parameters:
- IDLE_OP, 5'd0: value driven on alu_op when no grant is made.
- FIRST_PORT, 0: port that wins the first tie after reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req0_valid / req1_valid  in  1  operation request
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_a, req0_b / req1_a, req1_b  in  32  operands
- req0_shamt / req1_shamt  in  5  shift amount
- req0_op / req1_op  in  5  ALU opcode, passed through unmodified
- rsp0_valid / rsp1_valid  out  1  result held for the port
- rsp0_result / rsp1_result  out  32  registered ALU result
- rsp0_ready / rsp1_ready  in  1  requester consumes the result
- alu_a, alu_b  out  32  to shared ALU A/B
- alu_shamt  out  5  to shared ALU shamt
- alu_op  out  5  to shared ALU ALUOp
- alu_result  in  32  from shared ALU Result

## Operation
- State:
  - rspN_valid and rspN_result (N = 0, 1).
  - last_grant (1 bit).
- Port N is eligible when reqN_valid is high and its response slot can accept a new result: either !rspN_valid, or (rspN_valid && rspN_ready) in the same cycle.
- Grant rules:
  - Exactly one eligible port: grant it.
  - Both eligible: grant port !last_grant.
  - Neither eligible: no grant.
- reqN_ready = grant to port N. The request handshake completes on reqN_valid && reqN_ready.
- Granted cycle:
  - alu_a/alu_b/alu_shamt/alu_op carry the granted port's fields combinationally.
  - At the clock edge: rspN_result <= alu_result, rspN_valid <= 1, last_grant <= N.
- Ungranted cycle: alu_a = alu_b = 0, alu_shamt = 0, alu_op = IDLE_OP. last_grant holds.
- Response handshake: rspN_valid && rspN_ready with no new grant to N clears rspN_valid at the edge. rspN_result holds its last value.
- Simultaneous drain and grant on the same port: the new result overwrites and rspN_valid stays 1. Back-to-back issue gives one op per cycle per port.
- A port with a full, undrained slot is never granted. The other port may take every cycle meanwhile.
- Opcode values are not decoded. Unknown opcodes propagate to the ALU, and its result (0 for unknown ops) is returned.
- Width rules: 32-bit data and 5-bit op/shamt are carried unchanged, with no extension or truncation.

## Timing
- Reset (asynchronous, immediate):
  - rsp0_valid = rsp1_valid = 0, rsp0_result = rsp1_result = 0.
  - last_grant = !FIRST_PORT.
  - While reset is high: req0_ready = req1_ready = 0, ALU outputs at idle values.
- Reset mid-operation: held results are discarded. Requests presented during reset are not accepted and must be re-presented.
- Latency: request accepted at edge t gives rspN_valid = 1 and the result visible after edge t (cycle t+1).
- Throughput: one grant per cycle total, across both ports.
- Fairness under continuous contention: strict alternation 0,1,0,1…
- Combinational paths:
  - reqN_valid, rspN_ready -> reqN_ready.
  - req fields -> alu_*.
  - No path from alu_result to any output except through the registers.

## Test plan
- Reset then single op: req0 {a=5, b=3, op=ADD} for one cycle, rsp0_ready=1 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_result=8; then rsp0_valid=0.
- Contention: both ports valid every cycle, with req0 SUB(10,4) and req1 OR(0xF0,0x0F), rsp ready high -> grants 0,1,0,1… (port 0 first with FIRST_PORT=0); rsp0_result=6, rsp1_result=0xFF.
- Backpressure: rsp1_ready=0 after one accepted op -> req1_ready stays 0 while req0 is granted every cycle; raise rsp1_ready -> req1 granted the same cycle the old result drains.
- Back-to-back same port: req0 SLL with b=1 and shamt 1,2,3 on consecutive cycles, rsp0_ready=1 -> rsp0_result 2,4,8 on consecutive cycles, rsp0_valid continuously 1.
- Idle outputs: no requests -> alu_a=alu_b=0, alu_shamt=0, alu_op=IDLE_OP; unknown op 5'h1F with alu_result 0 -> rsp result 0.
- Async reset mid-flight: assert reset between clock edges while rsp0_valid=1 -> rsp0_valid=0, rsp0_result=0 immediately; after release, the first tie goes to FIRST_PORT.
